// File: rtl/lenet_run_sequencer.sv
// lenet_run_sequencer: steps a LeNet core through a batch of images, one
// start/finish handshake per image, and reports the argmax class of each run.
// Optional watchdog on the core handshake: define SEQ_TIMEOUT_EN.
module lenet_run_sequencer #(
   parameter int unsigned OUTPUT_NODE    = 10,
   parameter int unsigned DATA_SIZE      = 8,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst_n,
   input  logic                            run,
   input  logic [4:0]                      num_graphs,
   output logic                            start,
   output logic [4:0]                      graph,
   input  logic                            lenet_finish,
   input  logic [DATA_SIZE*OUTPUT_NODE-1:0] result,
   output logic [3:0]                      class_id,
   output logic [DATA_SIZE-1:0]            class_score,
   output logic                            class_valid,
   output logic                            busy,
   output logic                            done,
   output logic                            timeout_err
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_ARGMAX, S_REPORT, S_GAP, S_DONE
   } state_t;

   state_t                       state;
   logic [4:0]                   count_q;
   logic [3:0]                   scan_idx;
   logic [GAP_W-1:0]             gap_cnt;
   logic [3:0]                   best_idx;
   logic signed [DATA_SIZE-1:0]  best_score;
   logic signed [DATA_SIZE-1:0]  node_q [OUTPUT_NODE];
   logic                         take_node;
   logic [3:0]                   nxt_idx;
   logic signed [DATA_SIZE-1:0]  nxt_score;

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0]              wd_cnt;
`else
   // Watchdog limit has no effect when the watchdog is not built.
   logic                         unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign timeout_err        = 1'b0;
`endif

   // Running argmax: first node seeds, later nodes win only if strictly greater.
   always_comb begin
      take_node = (scan_idx == 4'd0) || (node_q[scan_idx] > best_score);
      nxt_idx   = take_node ? scan_idx : best_idx;
      nxt_score = take_node ? node_q[scan_idx] : best_score;
   end

   // Sequencer FSM with registered handshake and report outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= S_IDLE;
         start       <= 1'b0;
         graph       <= 5'd0;
         count_q     <= 5'd0;
         scan_idx    <= 4'd0;
         gap_cnt     <= '0;
         best_idx    <= 4'd0;
         best_score  <= '0;
         class_id    <= 4'd0;
         class_score <= '0;
         class_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         for (int unsigned k = 0; k < OUTPUT_NODE; k++) node_q[k] <= '0;
`ifdef SEQ_TIMEOUT_EN
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         class_valid <= 1'b0;
         done        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) begin
                  count_q <= num_graphs;
                  graph   <= 5'd1;
                  busy    <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                  timeout_err <= 1'b0;
`endif
                  if (num_graphs == 5'd0) begin
                     state <= S_DONE;
                  end else begin
                     start <= 1'b1;
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
`ifdef SEQ_TIMEOUT_EN
               wd_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (lenet_finish) begin
                  for (int unsigned k = 0; k < OUTPUT_NODE; k++)
                     node_q[k] <= result[k*DATA_SIZE +: DATA_SIZE];
                  start    <= 1'b0;
                  scan_idx <= 4'd0;
                  state    <= S_ARGMAX;
               end
`ifdef SEQ_TIMEOUT_EN
               else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  start       <= 1'b0;
                  timeout_err <= 1'b1;
                  class_valid <= 1'b1;
                  class_id    <= 4'hF;
                  class_score <= '0;
                  state       <= S_REPORT;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
`endif
            end
            S_ARGMAX: begin
               best_idx   <= nxt_idx;
               best_score <= nxt_score;
               if (scan_idx == 4'(OUTPUT_NODE - 1)) begin
                  class_valid <= 1'b1;
                  class_id    <= nxt_idx;
                  class_score <= nxt_score;
                  state       <= S_REPORT;
               end else begin
                  scan_idx <= scan_idx + 4'd1;
               end
            end
            S_REPORT: begin
               if (graph == count_q) begin
                  state <= S_DONE;
               end else begin
                  graph   <= graph + 5'd1;
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  start <= 1'b1;
                  state <= S_REQ;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lenet_run_sequencer.sv
// Directed bench for lenet_run_sequencer (10 nodes x 8 bits, gap 4, watchdog 100).
module tb_lenet_run_sequencer;

   localparam int unsigned ON = 10;
   localparam int unsigned DS = 8;
   localparam int unsigned GC = 4;
   localparam int unsigned TC = 100;

   logic              clk;
   logic              rst_n;
   logic              run;
   logic [4:0]        num_graphs;
   logic              start;
   logic [4:0]        graph;
   logic              lenet_finish;
   logic [ON*DS-1:0]  result;
   logic [3:0]        class_id;
   logic [DS-1:0]     class_score;
   logic              class_valid;
   logic              busy;
   logic              done;
   logic              timeout_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cv_cnt  = 0;
   int done_cnt = 0;

   lenet_run_sequencer #(
      .OUTPUT_NODE(ON), .DATA_SIZE(DS), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TC)
   ) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .run(run), .num_graphs(num_graphs),
      .start(start), .graph(graph), .lenet_finish(lenet_finish), .result(result),
      .class_id(class_id), .class_score(class_score), .class_valid(class_valid),
      .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters for class_valid and done.
   always @(negedge clk) begin
      if (class_valid === 1'b1) cv_cnt++;
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ON*DS-1:0] fill(input logic [DS-1:0] v);
      logic [ON*DS-1:0] r;
      for (int k = 0; k < ON; k++) r[k*DS +: DS] = v;
      return r;
   endfunction

   // One-image batch: finish after a few cycles, then check argmax report timing.
   task automatic single_run(input string tag, input logic [ON*DS-1:0] r,
                             input logic [3:0] exp_id, input logic [DS-1:0] exp_sc);
      result = r; num_graphs = 5'd1; run = 1'b1;
      tick();
      run = 1'b0; num_graphs = 5'd9;
      check({tag, "_start"}, 32'(start), 32'd1);
      check({tag, "_graph"}, 32'(graph), 32'd1);
      repeat (3) tick();
      lenet_finish = 1'b1;
      tick();
      lenet_finish = 1'b0;
      result = fill(8'h00);
      check({tag, "_start_drop"}, 32'(start), 32'd0);
      repeat (9) tick();
      check({tag, "_cv_early"}, 32'(class_valid), 32'd0);
      tick();
      check({tag, "_cv"}, 32'(class_valid), 32'd1);
      check({tag, "_id"}, 32'(class_id), 32'(exp_id));
      check({tag, "_score"}, 32'(class_score), 32'(exp_sc));
      tick();
      check({tag, "_cv_late"}, 32'(class_valid), 32'd0);
      tick();
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      tick();
   endtask

   initial begin
      logic [ON*DS-1:0] r;
      int n, cv0, d0;

      rst_n = 1'b0; run = 1'b0; num_graphs = 5'd0; lenet_finish = 1'b0; result = '0;
      repeat (2) tick();
      check("rst_start", 32'(start), 32'd0);
      check("rst_graph", 32'(graph), 32'd0);
      check("rst_class_id", 32'(class_id), 32'd0);
      check("rst_class_score", 32'(class_score), 32'd0);
      check("rst_class_valid", 32'(class_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Empty batch: straight to DONE.
      num_graphs = 5'd0; run = 1'b1;
      tick();
      run = 1'b0;
      check("zero_busy1", 32'(busy), 32'd1);
      check("zero_done_early", 32'(done), 32'd0);
      check("zero_no_start", 32'(start), 32'd0);
      tick();
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy2", 32'(busy), 32'd0);
      tick();
      check("zero_done_once", 32'(done), 32'd0);

      // Argmax patterns.
      r = fill(8'h10); r[7*DS +: DS] = 8'h7F;
      single_run("n7", r, 4'd7, 8'h7F);
      r = fill(8'hF0); r[2*DS +: DS] = 8'h40; r[5*DS +: DS] = 8'h40;
      single_run("tie", r, 4'd2, 8'h40);
      single_run("all80", fill(8'h80), 4'd0, 8'h80);
      r = fill(8'h80); r[9*DS +: DS] = 8'h01;
      single_run("last", r, 4'd9, 8'h01);

      // Stray finish while idle.
      lenet_finish = 1'b1;
      tick();
      lenet_finish = 1'b0;
      repeat (12) tick();
      check("stray_busy", 32'(busy), 32'd0);
      check("stray_cv", 32'(class_valid), 32'd0);

      // Three-image batch, core finishes 50 cycles after each start rise.
      r = fill(8'h01); r[3*DS +: DS] = 8'h55;
      result = r; num_graphs = 5'd3; run = 1'b1;
      cv0 = cv_cnt; d0 = done_cnt;
      tick();
      run = 1'b0;
      for (int g = 1; g <= 3; g++) begin
         check("batch_start", 32'(start), 32'd1);
         check("batch_graph", 32'(graph), 32'(g));
         repeat (10) tick();
         run = 1'b1; num_graphs = 5'd1;
         tick();
         run = 1'b0; num_graphs = 5'd0;
         repeat (39) tick();
         check("batch_graph_stable", 32'(graph), 32'(g));
         lenet_finish = 1'b1;
         tick();
         lenet_finish = 1'b0;
         n = 1;
         while (class_valid !== 1'b1 && n < 40) begin tick(); n++; end
         check("batch_cv_latency", 32'(n), 32'd11);
         check("batch_id", 32'(class_id), 32'd3);
         if (g < 3) begin
            n = 0;
            while (start !== 1'b1 && n < 40) begin tick(); n++; end
            check("batch_gap", 32'(n), 32'(GC + 1));
         end
      end
      n = 0;
      while (done !== 1'b1 && n < 40) begin tick(); n++; end
      check("batch_done_lat", 32'(n), 32'd2);
      tick();
      check("batch_cv_count", 32'(cv_cnt - cv0), 32'd3);
      check("batch_done_count", 32'(done_cnt - d0), 32'd1);

      // Reset during WAIT of graph 2 abandons the batch.
      num_graphs = 5'd3; run = 1'b1;
      tick();
      run = 1'b0;
      repeat (20) tick();
      lenet_finish = 1'b1;
      tick();
      lenet_finish = 1'b0;
      n = 0;
      while (start !== 1'b1 && n < 40) begin tick(); n++; end
      check("rmid_graph2", 32'(graph), 32'd2);
      repeat (10) tick();
      cv0 = cv_cnt; d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("rmid_start", 32'(start), 32'd0);
      check("rmid_busy", 32'(busy), 32'd0);
      check("rmid_class_id", 32'(class_id), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (30) tick();
      check("rmid_no_cv", 32'(cv_cnt - cv0), 32'd0);
      check("rmid_no_done", 32'(done_cnt - d0), 32'd0);
      check("rmid_idle_start", 32'(start), 32'd0);
      r = fill(8'h22); r[4*DS +: DS] = 8'h33;
      single_run("rmid_rerun", r, 4'd4, 8'h33);

`ifdef SEQ_TIMEOUT_EN
      // Core never finishes: watchdog expires on both images.
      num_graphs = 5'd2; run = 1'b1;
      tick();
      run = 1'b0;
      for (int g = 1; g <= 2; g++) begin
         n = 0;
         while (start !== 1'b1 && n < 40) begin tick(); n++; end
         n = 0;
         while (start === 1'b1 && n < 300) begin tick(); n++; end
         check("wd_start_len", 32'(n), 32'(TC + 1));
         check("wd_cv", 32'(class_valid), 32'd1);
         check("wd_id", 32'(class_id), 32'hF);
         check("wd_score", 32'(class_score), 32'd0);
         check("wd_err", 32'(timeout_err), 32'd1);
      end
      n = 0;
      while (done !== 1'b1 && n < 40) begin tick(); n++; end
      check("wd_done", 32'(done), 32'd1);
      tick();
      check("wd_err_sticky", 32'(timeout_err), 32'd1);
      num_graphs = 5'd0; run = 1'b1;
      tick();
      run = 1'b0;
      check("wd_err_clear", 32'(timeout_err), 32'd0);
      repeat (3) tick();
`else
      check("no_wd_err", 32'(timeout_err), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lenet_run_sequencer.md
LENET_RUN_SEQUENCER -- requirements
Module: lenet_run_sequencer

Interface
REQ-001 SHALL have parameter OUTPUT_NODE, default 10, number of class scores in result.
REQ-002 SHALL have parameter DATA_SIZE, default 8, width of one signed class score.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, start-low cycles between consecutive runs (min 1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, watchdog limit per run.
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-007 run  in  1  batch request; sampled only in IDLE.
REQ-008 num_graphs  in  5  number of images in batch; latched when run is accepted.
REQ-009 start  out  1  level request to the LeNet core; high for the whole run.
REQ-010 graph  out  5  image index presented to the core; stable while start high.
REQ-011 lenet_finish  in  1  core completion; valid only while start high.
REQ-012 result  in  DATA_SIZE*OUTPUT_NODE  class scores, node k at bits [k*DATA_SIZE +: DATA_SIZE].
REQ-013 class_id  out  4  argmax index of last run; 4'hF on timeout.
REQ-014 class_score  out  DATA_SIZE  winning score of last run.
REQ-015 class_valid  out  1  one-cycle pulse per completed run.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when batch ends.
REQ-018 timeout_err  out  1  sticky watchdog flag.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, ARGMAX, REPORT, GAP, DONE.
REQ-020 IDLE: run=1 SHALL latch num_graphs, set graph=1, clear timeout_err, go REQ; if num_graphs=0 go DONE directly.
REQ-021 REQ: start SHALL rise; next cycle go WAIT.
REQ-022 WAIT: start held high; on lenet_finish=1 SHALL capture result into an internal register, drop start next cycle, go ARGMAX.
REQ-023 ARGMAX: SHALL scan nodes 0..OUTPUT_NODE-1, one node per cycle, signed compare; ties keep the lower index.
REQ-024 class_valid SHALL pulse exactly OUTPUT_NODE+1 cycles after the cycle lenet_finish is sampled high (REPORT state).
REQ-025 class_id and class_score SHALL update in the class_valid cycle and hold until the next update.
REQ-026 REPORT: if graph = latched count go DONE; else increment graph, go GAP.
REQ-027 GAP: start SHALL stay low for GAP_CYCLES cycles, then go REQ.
REQ-028 DONE: done SHALL pulse one cycle, then go IDLE.
REQ-029 run while busy SHALL be ignored; lenet_finish outside WAIT SHALL be ignored.
REQ-030 Changes on the num_graphs input during a batch SHALL NOT affect it.

Reset
REQ-031 sys_rst_n low SHALL asynchronously force IDLE, start=0, graph=0, class_id=0, class_score=0, class_valid=0, busy=0, done=0, timeout_err=0, all counters and captured result 0.
REQ-032 Reset mid-run SHALL drop start immediately and abandon the batch; no class_valid or done pulse.

Configuration
REQ-033 With SEQ_TIMEOUT_EN defined, WAIT SHALL count cycles; on reaching TIMEOUT_CYCLES without finish: drop start, set timeout_err, pulse class_valid with class_id=4'hF and class_score=0, then continue per REQ-026.
REQ-034 Without SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, no watchdog counter SHALL exist, and timeout_err SHALL be constant 0.

Verification
REQ-035 num_graphs=3, core finishes 50 cycles after each start rise -> start high runs with graph=1,2,3, gaps of exactly GAP_CYCLES cycles, three class_valid pulses, one done pulse.
REQ-036 result with node7=0x7F and all other nodes 0x10 -> class_id=7, class_score=0x7F, class_valid exactly 11 cycles after finish.
REQ-037 nodes 2 and 5 both 0x40, all others 0xF0 (negative) -> class_id=2; all nodes 0x80 -> class_id=0, class_score=0x80.
REQ-038 num_graphs=0 -> no start pulse, done pulses 2 cycles after run, busy high for exactly 1 cycle.
REQ-039 sys_rst_n low during WAIT of graph 2 -> start=0 same cycle, IDLE, no done; new run afterwards restarts at graph=1.
REQ-040 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, core never finishes -> start drops after 100 WAIT cycles, class_id=4'hF, timeout_err=1 until next accepted run.
